button_event_unit: RTL and testbench

Parametrised input conditioner for the board push-buttons feeding the processor: the game buttons (left/right per player) and KEY[3:0].
- Per channel: synchronises, debounces and detects edges, with optional hold-to-repeat.
- Serialises press/release/repeat events into a show-ahead FIFO that the processor pops through a valid/read handshake.
- Replaces raw per-button wiring into the processor; one instance per button group.

---
 rtl/btn_pkg.sv | 18 +
 rtl/button_event_unit_if.sv | 13 +
 rtl/btn_debounce.sv | 80 ++++++++
 rtl/button_event_unit.sv | 130 +++++++++++++
 tb/tb_button_event_unit.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button event unit: event type codes and width helpers.
package btn_pkg;

   localparam logic [1:0] EVT_PRESS   = 2'b00;
   localparam logic [1:0] EVT_RELEASE = 2'b01;
   localparam logic [1:0] EVT_REPEAT  = 2'b10;

   // Channel index width; a single channel still carries a 1-bit index.
   function automatic int unsigned idxw(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Width of a counter that must hold 0 .. n-1.
   function automatic int unsigned cntw(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_event_unit_if.sv
// Event FIFO read port: show-ahead data with a valid/read handshake and occupancy.
interface button_event_unit_if #(
   parameter int unsigned DW = 4,
   parameter int unsigned CW = 4
);
   logic          evt_valid;
   logic [DW-1:0] evt_data;
   logic          evt_rd;
   logic [CW-1:0] evt_count;

   modport master (output evt_valid, output evt_data, output evt_count, input evt_rd);
   modport slave  (input evt_valid, input evt_data, input evt_count, output evt_rd);
endinterface

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, stable-count debounce, edge pulses and
// hold-to-repeat pulse generation.
module btn_debounce
   import btn_pkg::*;
#(
   parameter bit          ACTIVE_LOW   = 1'b1,
   parameter int unsigned DEBOUNCE_CYC = 500000,
   parameter int unsigned REPEAT_DELAY = 25000000,
   parameter int unsigned REPEAT_RATE  = 5000000
) (
   input  logic clock,
   input  logic resetn,
   input  logic btn_raw,
   input  logic repeat_en,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse
);

   localparam int unsigned DW = cntw(DEBOUNCE_CYC);
   localparam int unsigned HW = cntw((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

   logic          sync_q1, sync_q2;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;
   logic          rate_phase;
   logic          accept, hold_active, fire;

   always_comb begin
      accept      = (sync_q2 != level) && (deb_cnt == DEB_LAST);
      // An accept while pressed is the release edge; no repeat may fire with it.
      hold_active = level && repeat_en && !accept;
      fire        = hold_active && (hold_cnt == (rate_phase ? RATE_LAST : DELAY_LAST));
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_q1       <= 1'b0;
         sync_q2       <= 1'b0;
         deb_cnt       <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         repeat_pulse  <= 1'b0;
         hold_cnt      <= '0;
         rate_phase    <= 1'b0;
      end else begin
         sync_q1 <= btn_raw ^ ACTIVE_LOW;
         sync_q2 <= sync_q1;

         if (sync_q2 == level) begin
            deb_cnt <= '0;
         end else if (accept) begin
            deb_cnt <= '0;
            level   <= ~level;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end

         press_pulse   <= accept && !level;
         release_pulse <= accept && level;
         repeat_pulse  <= fire;

         if (!hold_active) begin
            hold_cnt   <= '0;
            rate_phase <= 1'b0;
         end else if (fire) begin
            hold_cnt   <= '0;
            rate_phase <= 1'b1;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_event_unit.sv
// Button group conditioner: per-channel debounce, pending-flag stage and a show-ahead
// event FIFO popped by the processor.
module button_event_unit
   import btn_pkg::*;
#(
   parameter int unsigned NUM_BTN      = 4,
   parameter bit          ACTIVE_LOW   = 1'b1,
   parameter int unsigned DEBOUNCE_CYC = 500000,
   parameter int unsigned REPEAT_DELAY = 25000000,
   parameter int unsigned REPEAT_RATE  = 5000000,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic [NUM_BTN-1:0]         btn_in,
   input  logic [NUM_BTN-1:0]         repeat_en,
   output logic [NUM_BTN-1:0]         btn_level,
   output logic [NUM_BTN-1:0]         press_pulse,
   output logic [NUM_BTN-1:0]         release_pulse,
   button_event_unit_if.master        evt,
   output logic                       overflow,
   input  logic                       clr_overflow
);

   localparam int unsigned IDXW = idxw(NUM_BTN);
   localparam int unsigned DW   = 2 + IDXW;
   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = PW + 1;

   typedef enum logic {StIdle, StPush} ser_state_e;

   logic [NUM_BTN-1:0] repeat_pulse;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_debounce #(
         .ACTIVE_LOW   (ACTIVE_LOW),
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_debounce (
         .clock         (clock),
         .resetn        (resetn),
         .btn_raw       (btn_in[i]),
         .repeat_en     (repeat_en[i]),
         .level         (btn_level[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .repeat_pulse  (repeat_pulse[i])
      );
   end

   logic [NUM_BTN-1:0] pend_prs_q, pend_rel_q, pend_rep_q;
   logic [NUM_BTN-1:0] pend_prs_d, pend_rel_d, pend_rep_d;
   logic [NUM_BTN-1:0] served, keep_prs, keep_rel, keep_rep;
   logic               sel_found, fifo_full, pop, push, drop;
   logic [IDXW-1:0]    sel_idx;
   logic [1:0]         sel_type;
   ser_state_e         ser_state;

   logic [DW-1:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]      count_q;
   logic               overflow_q;

   // Descending scan so the lowest pending channel is the one left selected.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_type  = EVT_PRESS;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (pend_rel_q[i] || pend_prs_q[i] || pend_rep_q[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDXW'(i);
            if (pend_rel_q[i])      sel_type = EVT_RELEASE;
            else if (pend_prs_q[i]) sel_type = EVT_PRESS;
            else                    sel_type = EVT_REPEAT;
         end
      end
   end

   always_comb begin
      fifo_full = (count_q == CW'(FIFO_DEPTH));
      pop       = evt.evt_rd && (count_q != '0);
      ser_state = (sel_found && (!fifo_full || pop)) ? StPush : StIdle;
      push      = (ser_state == StPush);

      served = '0;
      if (push) served[sel_idx] = 1'b1;
      keep_rel = pend_rel_q & ~(served & {NUM_BTN{sel_type == EVT_RELEASE}});
      keep_prs = pend_prs_q & ~(served & {NUM_BTN{sel_type == EVT_PRESS}});
      keep_rep = pend_rep_q & ~(served & {NUM_BTN{sel_type == EVT_REPEAT}});

      // A flag that is still occupied after this cycle's push cannot take a new event.
      drop = |(keep_rel & release_pulse) | |(keep_prs & press_pulse) | |(keep_rep & repeat_pulse);
      pend_rel_d = keep_rel | release_pulse;
      pend_prs_d = keep_prs | press_pulse;
      pend_rep_d = keep_rep | repeat_pulse;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pend_prs_q <= '0;
         pend_rel_q <= '0;
         pend_rep_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int k = 0; k < int'(FIFO_DEPTH); k++) mem_q[k] <= '0;
      end else begin
         pend_prs_q <= pend_prs_d;
         pend_rel_q <= pend_rel_d;
         pend_rep_q <= pend_rep_d;
         if (push) begin
            mem_q[wr_ptr_q] <= {sel_type, sel_idx};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(push) - CW'(pop);
         if (drop)              overflow_q <= 1'b1;
         else if (clr_overflow) overflow_q <= 1'b0;
      end
   end

   assign evt.evt_valid = (count_q != '0);
   assign evt.evt_data  = mem_q[rd_ptr_q];
   assign evt.evt_count = count_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_button_event_unit.sv
// Self-checking bench: directed button stimulus, a behavioural event model compared every
// cycle, and hand-computed expectations for latency, ordering and overflow.
module tb_button_event_unit;

   localparam int NB    = 4;
   localparam int DEB   = 4;
   localparam int DLY   = 20;
   localparam int RATE  = 8;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       resetn;
   logic [3:0] btn_in, repeat_en, btn_level, press_pulse, release_pulse;
   logic       overflow, clr_overflow;

   int checks   = 0;
   int failures = 0;

   button_event_unit_if #(.DW(4), .CW(3)) bus ();

   button_event_unit #(
      .NUM_BTN      (NB),
      .ACTIVE_LOW   (1'b1),
      .DEBOUNCE_CYC (DEB),
      .REPEAT_DELAY (DLY),
      .REPEAT_RATE  (RATE),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .btn_in        (btn_in),
      .repeat_en     (repeat_en),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .evt           (bus),
      .overflow      (overflow),
      .clr_overflow  (clr_overflow)
   );

   always #5 clock = ~clock;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void chk_range(string name, int act, int lo, int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
      end
   endfunction

   // Behavioural model: run length of disagreement, hold age, pending bits and an event queue.
   bit [3:0]   m_s1, m_s2, m_lvl, m_prs, m_rel, m_rep;
   bit [3:0]   m_pend [3];
   int         m_run [4];
   int         m_age [4];
   logic [3:0] m_q [$];
   bit         m_ovf;

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_rep = '0;
         for (int t = 0; t < 3; t++) m_pend[t] = '0;
         for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_age[c] = 0; end
         m_q.delete();
         m_ovf = 1'b0;
      end else begin
         int sel_ch, sel_ty;
         bit pop, push, drop;
         bit [3:0] np, nr, nt, was;
         pop = bus.evt_rd && (m_q.size() > 0);
         sel_ch = -1;
         sel_ty = 0;
         for (int c = 0; c < NB; c++) begin
            if (sel_ch < 0) begin
               if (m_pend[1][c])      begin sel_ch = c; sel_ty = 1; end
               else if (m_pend[0][c]) begin sel_ch = c; sel_ty = 0; end
               else if (m_pend[2][c]) begin sel_ch = c; sel_ty = 2; end
            end
         end
         push = (sel_ch >= 0) && ((m_q.size() < DEPTH) || pop);
         if (pop) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back({2'(sel_ty), 2'(sel_ch)});
            m_pend[sel_ty][sel_ch] = 1'b0;
         end
         drop = 1'b0;
         for (int c = 0; c < NB; c++) begin
            if (m_prs[c]) begin if (m_pend[0][c]) drop = 1'b1; else m_pend[0][c] = 1'b1; end
            if (m_rel[c]) begin if (m_pend[1][c]) drop = 1'b1; else m_pend[1][c] = 1'b1; end
            if (m_rep[c]) begin if (m_pend[2][c]) drop = 1'b1; else m_pend[2][c] = 1'b1; end
         end
         if (drop) m_ovf = 1'b1;
         else if (clr_overflow) m_ovf = 1'b0;

         was = m_lvl; np = '0; nr = '0; nt = '0;
         for (int c = 0; c < NB; c++) begin
            if (m_s2[c] != m_lvl[c]) begin
               m_run[c]++;
               if (m_run[c] == DEB) begin
                  m_lvl[c] = ~m_lvl[c];
                  m_run[c] = 0;
                  if (m_lvl[c]) np[c] = 1'b1; else nr[c] = 1'b1;
               end
            end else begin
               m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = ~btn_in[c];
            if (was[c] && m_lvl[c] && repeat_en[c]) begin
               m_age[c]++;
               if (m_age[c] == DLY || (m_age[c] > DLY && (m_age[c] - DLY) % RATE == 0)) nt[c] = 1'b1;
            end else begin
               m_age[c] = 0;
            end
         end
         m_prs = np; m_rel = nr; m_rep = nt;
      end
   end

   always @(negedge clock) begin
      chk("level", btn_level, m_lvl);
      chk("press_pulse", press_pulse, m_prs);
      chk("release_pulse", release_pulse, m_rel);
      chk("evt_valid", bus.evt_valid, m_q.size() != 0);
      chk("evt_count", bus.evt_count, m_q.size());
      if (m_q.size() != 0) chk("evt_data", bus.evt_data, m_q[0]);
      chk("overflow", overflow, m_ovf);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pop_check(input string name, input logic [3:0] exp);
      chk(name, {bus.evt_valid, bus.evt_data}, {1'b1, exp});
      bus.evt_rd = 1'b1;
      step(1);
      bus.evt_rd = 1'b0;
      step(1);
   endtask

   task automatic drain();
      for (int k = 0; k < 16 && bus.evt_valid; k++) begin
         bus.evt_rd = 1'b1;
         step(1);
      end
      bus.evt_rd = 1'b0;
      step(1);
   endtask

   logic [3:0] col_d [$];
   int         col_t [$];

   // Hold one pin low for 'hold' cycles, reading every event as it appears.
   task automatic hold_collect(input int ch, input int hold, input int tail);
      col_d.delete();
      col_t.delete();
      for (int c = 0; c < hold + tail; c++) begin
         if (c == 0)    btn_in[ch] = 1'b0;
         if (c == hold) btn_in[ch] = 1'b1;
         bus.evt_rd = bus.evt_valid;
         if (bus.evt_valid) begin
            col_d.push_back(bus.evt_data);
            col_t.push_back(c);
         end
         step(1);
      end
      bus.evt_rd = 1'b0;
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] exp_rep [6];
      int         exp_dt [5];
      logic [3:0] exp_full [7];
      int         lat;
      exp_rep  = '{4'h1, 4'h9, 4'h9, 4'h9, 4'h9, 4'h5};
      exp_dt   = '{0, 20, 28, 36, 44};
      exp_full = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h1, 4'h6};

      resetn = 1'b0; btn_in = 4'hF; repeat_en = '0; bus.evt_rd = 1'b0; clr_overflow = 1'b0;
      step(3);
      chk("rst_level", btn_level, 4'h0);
      chk("rst_press", press_pulse, 4'h0);
      chk("rst_valid", bus.evt_valid, 1'b0);
      chk("rst_count", bus.evt_count, 3'd0);
      chk("rst_overflow", overflow, 1'b0);
      resetn = 1'b1;
      step(4);

      // Clean press and release on channel 2.
      btn_in[2] = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         step(1);
         if (btn_level[2]) lat = k;
      end
      chk_range("press_latency", lat, 5, 7);
      chk("press_pulse_ch2", press_pulse, 4'b0100);
      step(40 - lat);
      btn_in[2] = 1'b1;
      step(12);
      chk("clean_count", bus.evt_count, 3'd2);
      pop_check("clean_press_evt", 4'h2);
      pop_check("clean_release_evt", 4'h6);
      chk("clean_empty", bus.evt_valid, 1'b0);

      // Three-cycle glitch on channel 0.
      btn_in[0] = 1'b0;
      step(3);
      btn_in[0] = 1'b1;
      step(12);
      chk("glitch_level", btn_level[0], 1'b0);
      chk("glitch_count", bus.evt_count, 3'd0);

      // Hold-to-repeat on channel 1, then the same hold with repeat disabled.
      repeat_en[1] = 1'b1;
      hold_collect(1, 50, 16);
      chk("rep_events", col_d.size(), 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("rep_evt%0d", i), (i < col_d.size()) ? col_d[i] : 4'bx, exp_rep[i]);
      for (int i = 1; i < 5; i++)
         chk($sformatf("rep_dt%0d", i), (i < col_t.size()) ? col_t[i] - col_t[0] : -1, exp_dt[i]);
      repeat_en[1] = 1'b0;
      hold_collect(1, 50, 16);
      chk("norep_events", col_d.size(), 2);
      chk("norep_press", (col_d.size() > 0) ? col_d[0] : 4'bx, 4'h1);
      chk("norep_release", (col_d.size() > 1) ? col_d[1] : 4'bx, 4'h5);

      // Channels 3 and 0 pressed together.
      btn_in = 4'b0110;
      step(12);
      chk("simul_count", bus.evt_count, 3'd2);
      pop_check("simul_first", 4'h0);
      pop_check("simul_second", 4'h3);
      btn_in = 4'hF;
      step(12);
      pop_check("simul_rel_first", 4'h4);
      pop_check("simul_rel_second", 4'h7);

      // Fill the FIFO, hold two pending, then collide on channel 1 release.
      btn_in = 4'b1000;
      step(12);
      btn_in = 4'hF;
      step(12);
      chk("full_count", bus.evt_count, 3'd4);
      chk("full_no_overflow", overflow, 1'b0);
      btn_in[1] = 1'b0;
      step(12);
      btn_in[1] = 1'b1;
      step(12);
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_count", bus.evt_count, 3'd4);
      for (int i = 0; i < 7; i++) pop_check($sformatf("full_pop%0d", i), exp_full[i]);
      chk("full_drained", bus.evt_count, 3'd0);
      clr_overflow = 1'b1;
      step(1);
      clr_overflow = 1'b0;
      step(1);
      chk("ovf_clear", overflow, 1'b0);

      // Reset while channel 1 is held.
      btn_in[1] = 1'b0;
      step(10);
      resetn = 1'b0;
      step(2);
      chk("rst2_level", btn_level, 4'h0);
      chk("rst2_valid", bus.evt_valid, 1'b0);
      chk("rst2_count", bus.evt_count, 3'd0);
      resetn = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         step(1);
         if (btn_level[1]) lat = k;
      end
      chk_range("rst2_press_latency", lat, 5, 7);
      step(2);
      chk("rst2_press_evt", {bus.evt_valid, bus.evt_data}, 5'b1_0001);
      btn_in[1] = 1'b1;
      step(12);
      drain();
      chk("final_empty", bus.evt_count, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
